fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined core. It keeps its own shadow pipeline of destination tags from EX through WB and issues registered one-hot operand-forwarding selects for the instruction entering EX. It raises a same-cycle stall on load-use hazards. It sits beside the ID/EX pipeline register and drives the EX-stage operand muxes and the IF/ID hold logic.

## Interface
- `REG_ADDR_W`, 5: register-address width.
- `N_FWD`, 2: number of forwardable stages after EX (stage 1 = EX/MEM … stage N_FWD = WB); must be ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_ADDR_W: ID source registers.
- `id_rd` in REG_ADDR_W: ID destination register.
- `id_reg_write` in 1: ID instruction writes `id_rd`.
- `id_is_load` in 1: ID instruction is a load (result available from stage 2 onward).
- `flush` in 1: kill the ID instruction (branch resolved in EX).
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX.
- `fwd_a`, `fwd_b` out N_FWD+1: one-hot operand selects for EX. Bit 0 = register file, bit k = stage k.
- `ex_valid` out 1: EX holds a real instruction.
- `perf_stall_cnt`, `perf_fwd_cnt` out 32: present only with `FWD_PERF_CNT_EN`.

## Operation
- Shadow pipeline: entries 0..N_FWD (0 = EX), each {valid, rd, reg_write, is_load}. It shifts every cycle; entry k+1 takes entry k.
- Entry 0 load:
  - From ID when `id_valid && !stall && !flush`.
  - Otherwise a bubble (valid=0).
- Match at entry k: `valid && reg_write && rd == src && src != 0`. Register 0 never forwards and never stalls.
- Forwarding select:
  - On each cycle, the source's select for the next cycle is computed against current entries 0..N_FWD-1, which become stages 1..N_FWD.
  - Youngest match wins: current entry 0 → bit 1, entry 1 → bit 2, and so on.
  - No match → bit 0.
  - The result is registered into `fwd_a`/`fwd_b`.
  - When the next EX is a bubble, both selects register to bit 0.
- Load-use: `stall` = `id_valid && !flush` && entry 0 is a valid load writing a nonzero rd equal to `id_rs` or `id_rt`.
  - Combinational, asserted the same cycle.
  - Lasts exactly one cycle per hazard. The next cycle the load sits in entry 1 and the re-evaluated select picks bit 2.
- Flush priority: `flush` forces `stall`=0 and inserts a bubble into entry 0. Entries already past ID are unaffected.
- `id_valid`=0 never stalls and never creates an entry.

## Timing
- Reset (async assert, sync release):
  - All entries invalid.
  - `fwd_a`=`fwd_b`=one-hot bit 0 (3'b001 for N_FWD=2).
  - `ex_valid`=0, `stall`=0, perf counters 0.
- Select latency: ID inputs sampled at edge n; `fwd_*` valid from edge n through n+1, aligned with the instruction in EX.
- `stall` has zero latency from ID inputs and must settle before the edge.
- Reset mid-stall clears the shadow pipeline. The first instruction after reset sees no producers.
- A same-register match in several stages always resolves to the lowest stage index. The encoding is never multi-hot.

## Configuration
- `FWD_PERF_CNT_EN` defined:
  - `perf_stall_cnt` increments on every cycle with `stall`=1.
  - `perf_fwd_cnt` increments on every edge where a registered select for a valid EX instruction has any bit other than 0 set. It increments by at most 1 per cycle.
  - Both counters saturate at all-ones.
- `FWD_PERF_CNT_EN` undefined: ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `fwd_pkg`:
  - Shadow-entry struct typedef.
  - `FWD_SEL_RF` constant (bit 0).
  - Function building a one-hot select from a stage index.
- One sub-module, `fwd_match`:
  - Instantiated once per source operand.
  - Priority-compares one source against N_FWD entries and returns a one-hot select.

## Test plan
- Reset, N_FWD=2 → `fwd_a`=`fwd_b`=3'b001, `stall`=0, `ex_valid`=0.
- `add r3` then `sub` reading rs=r3 next cycle → `fwd_a`=3'b010 while `sub` is in EX; `fwd_b`=3'b001.
- Writer of r3, one unrelated instruction, then reader of r3 → `fwd_b`=3'b100. Two r3 writers back-to-back, then a reader → 3'b010 (youngest wins).
- `lw r5` followed by a reader of r5:
  - `stall`=1 for one cycle; EX gets a bubble with `fwd_*`=3'b001.
  - Then the reader enters EX with `fwd_a`=3'b100; `perf_stall_cnt`=1.
- Writer to r0, then reader of r0 → selects 3'b001, `stall`=0.
- Load-use hazard present with `flush`=1 the same cycle → `stall`=0, next `ex_valid`=0, selects 3'b001.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int REG_ADDR_W_MAX = 8;
  localparam int FWD_SEL_W_MAX  = 16;

  localparam logic [FWD_SEL_W_MAX-1:0] FWD_SEL_RF = FWD_SEL_W_MAX'(1);

  // rd is stored at the widest supported address width; narrower cores zero-extend
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_MAX-1:0] rd;
    logic                      reg_write;
    logic                      is_load;
  } shd_entry_t;

  function automatic logic [FWD_SEL_W_MAX-1:0] fwd_onehot(input int unsigned stage);
    fwd_onehot = FWD_SEL_RF << stage;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source register against the shadow entries that
// become stages 1..N_FWD on the next edge; produces a one-hot operand select.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int N_FWD      = 2
) (
  input  logic [REG_ADDR_W-1:0]         src,
  input  shd_entry_t [N_FWD-1:0]        entries,
  output logic [N_FWD:0]                sel
);

  logic [REG_ADDR_W_MAX-1:0] src_ext;

  assign src_ext = REG_ADDR_W_MAX'(src);

  // Scan oldest to youngest so the youngest producer overwrites older matches
  always_comb begin
    sel = (N_FWD+1)'(FWD_SEL_RF);
    for (int k = N_FWD-1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].reg_write &&
          (src_ext != '0) && (entries[k].rd == src_ext)) begin
        sel = (N_FWD+1)'(fwd_onehot(unsigned'(k + 1)));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generation for the EX operand muxes.
// Optional saturating performance counters when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int N_FWD      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [N_FWD:0]        fwd_a,
  output logic [N_FWD:0]        fwd_b,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_fwd_cnt,
`endif
  output logic                  ex_valid
);

  shd_entry_t [N_FWD:0] shd_p;
  shd_entry_t           ent_id;
  logic [N_FWD:0]       sel_a;
  logic [N_FWD:0]       sel_b;
  logic                 ld_hit;
  logic                 issue;
  logic                 unused_shd;

  assign ld_hit = shd_p[0].valid && shd_p[0].is_load && shd_p[0].reg_write &&
                  (shd_p[0].rd != '0) &&
                  ((shd_p[0].rd == REG_ADDR_W_MAX'(id_rs)) ||
                   (shd_p[0].rd == REG_ADDR_W_MAX'(id_rt)));

  assign stall    = id_valid && !flush && ld_hit;
  assign issue    = id_valid && !stall && !flush;
  assign ex_valid = shd_p[0].valid;

  // The WB entry and deeper is_load flags ride along but never steer a select
  assign unused_shd = ^shd_p;

  always_comb begin
    ent_id.valid     = issue;
    ent_id.rd        = REG_ADDR_W_MAX'(id_rd);
    ent_id.reg_write = id_reg_write;
    ent_id.is_load   = id_is_load;
  end

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .N_FWD(N_FWD)) u_match_a (
    .src     (id_rs),
    .entries (shd_p[N_FWD-1:0]),
    .sel     (sel_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .N_FWD(N_FWD)) u_match_b (
    .src     (id_rt),
    .entries (shd_p[N_FWD-1:0]),
    .sel     (sel_b)
  );

  // ID -> EX boundary: shadow shift and registered selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= N_FWD; k++) shd_p[k].valid <= 1'b0;
      fwd_a <= (N_FWD+1)'(FWD_SEL_RF);
      fwd_b <= (N_FWD+1)'(FWD_SEL_RF);
    end else begin
      shd_p[0] <= ent_id;
      for (int k = 1; k <= N_FWD; k++) shd_p[k] <= shd_p[k-1];
      fwd_a <= issue ? sel_a : (N_FWD+1)'(FWD_SEL_RF);
      fwd_b <= issue ? sel_b : (N_FWD+1)'(FWD_SEL_RF);
    end
  end

`ifdef FWD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  logic fwd_hit;

  assign fwd_hit = issue && (((sel_a | sel_b) & ~(N_FWD+1)'(FWD_SEL_RF)) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      perf_stall_cnt <= sat_inc(perf_stall_cnt, stall);
      perf_fwd_cnt   <= sat_inc(perf_fwd_cnt, fwd_hit);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed ID-stage vectors with
// hand-computed stall / EX-select expectations checked by a negedge monitor.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [2:0] fwd_a;
  logic [2:0] fwd_b;
  logic       ex_valid;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int step = 0;

  typedef struct {
    int         cyc;
    int         step;
    logic       exv;
    logic [2:0] a;
    logic [2:0] b;
  } out_t;

  typedef struct {
    int   step;
    logic st;
  } st_t;

  out_t out_q[$];
  st_t  stall_q[$];

  fwd_hazard_unit #(.REG_ADDR_W(5), .N_FWD(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
`ifdef FWD_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt),
`endif
    .ex_valid     (ex_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fl, input logic es, input logic ev,
                       input logic [2:0] ea, input logic [2:0] eb);
    @(posedge clk);
    #1;
    step++;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    flush        = fl;
    stall_q.push_back('{step: step, st: es});
    out_q.push_back('{cyc: cyc, step: step, exv: ev, a: ea, b: eb});
  endtask

  // Monitor: stall is checked in its own cycle, EX outputs one cycle later
  always @(negedge clk) begin
    if (stall_q.size() > 0) begin
      st_t s;
      s = stall_q.pop_front();
      chk($sformatf("s%0d_stall", s.step), 32'(stall), 32'(s.st));
    end
    if (out_q.size() > 0 && out_q[0].cyc < cyc) begin
      out_t o;
      o = out_q.pop_front();
      chk($sformatf("s%0d_ex_valid", o.step), 32'(ex_valid), 32'(o.exv));
      chk($sformatf("s%0d_fwd_a", o.step), 32'(fwd_a), 32'(o.a));
      chk($sformatf("s%0d_fwd_b", o.step), 32'(fwd_b), 32'(o.b));
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", 32'(fwd_a), 32'h1);
    chk("rst_fwd_b", 32'(fwd_b), 32'h1);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
`ifdef FWD_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    chk("rst_perf_fwd", perf_fwd_cnt, 32'h0);
`endif
    rst_n = 1'b1;

    //     v  rs  rt  rd  rw ld fl  stall exv  fwd_a   fwd_b
    issue(1, 1,  2,  3,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 1 add r3
    issue(1, 3,  4,  6,  1, 0, 0,  0,    1,   3'b010, 3'b001); // 2 sub reads r3
    issue(0, 0,  0,  0,  0, 0, 0,  0,    0,   3'b001, 3'b001); // 3 idle
    issue(1, 1,  2,  3,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 4 writer r3
    issue(1, 1,  2,  7,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 5 unrelated
    issue(1, 8,  3,  9,  1, 0, 0,  0,    1,   3'b001, 3'b100); // 6 reader r3 from stage 2
    issue(1, 0,  0,  3,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 7 writer r3
    issue(1, 0,  0,  3,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 8 writer r3
    issue(1, 3,  3,  10, 1, 0, 0,  0,    1,   3'b010, 3'b010); // 9 youngest wins
    issue(0, 0,  0,  0,  0, 0, 0,  0,    0,   3'b001, 3'b001); // 10
    issue(0, 0,  0,  0,  0, 0, 0,  0,    0,   3'b001, 3'b001); // 11
    issue(1, 1,  0,  5,  1, 1, 0,  0,    1,   3'b001, 3'b001); // 12 lw r5
    issue(1, 5,  2,  11, 1, 0, 0,  1,    0,   3'b001, 3'b001); // 13 load-use stall
    issue(1, 5,  2,  11, 1, 0, 0,  0,    1,   3'b100, 3'b001); // 14 reader after bubble
`ifdef FWD_PERF_CNT_EN
    chk("perf_stall_after_lu", perf_stall_cnt, 32'd1);
`endif
    issue(1, 1,  2,  0,  1, 0, 0,  0,    1,   3'b001, 3'b001); // 15 writer r0
`ifdef FWD_PERF_CNT_EN
    chk("perf_fwd_count", perf_fwd_cnt, 32'd4);
`endif
    issue(1, 0,  0,  12, 1, 0, 0,  0,    1,   3'b001, 3'b001); // 16 reader r0
    issue(1, 1,  0,  5,  1, 1, 0,  0,    1,   3'b001, 3'b001); // 17 lw r5
    issue(1, 5,  5,  13, 1, 0, 1,  0,    0,   3'b001, 3'b001); // 18 hazard + flush
    issue(0, 0,  0,  0,  0, 0, 0,  0,    0,   3'b001, 3'b001); // 19
    issue(1, 0,  0,  5,  1, 1, 0,  0,    1,   3'b001, 3'b001); // 20 lw r5
    issue(1, 5,  0,  13, 1, 0, 0,  1,    0,   3'b001, 3'b001); // 21 stall, then reset

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_ex_valid", 32'(ex_valid), 32'h0);
    chk("midrst_fwd_a", 32'(fwd_a), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    id_valid = 1'b0;
`ifdef FWD_PERF_CNT_EN
    chk("midrst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    issue(1, 5,  0,  13, 1, 0, 0,  0,    1,   3'b001, 3'b001); // 22 no producers after reset
    issue(0, 0,  0,  0,  0, 0, 0,  0,    0,   3'b001, 3'b001); // 23

    begin
      int n = 0;
      while ((stall_q.size() > 0 || out_q.size() > 0) && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (stall_q.size() > 0 || out_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending=%0d required=0", stall_q.size() + out_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
